// File: rtl/hdmi_timing_pkg.sv
// Shared 720p60 timing constants and RGB565 helpers for the HDMI input and output paths.
package hdmi_timing_pkg;

  localparam int unsigned H_ACT_720P   = 1280;
  localparam int unsigned H_FP_720P    = 110;
  localparam int unsigned H_SYNC_720P  = 40;
  localparam int unsigned H_BP_720P    = 220;
  localparam int unsigned H_TOTAL_720P = H_ACT_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;

  localparam int unsigned V_ACT_720P   = 720;
  localparam int unsigned V_FP_720P    = 5;
  localparam int unsigned V_SYNC_720P  = 5;
  localparam int unsigned V_BP_720P    = 20;
  localparam int unsigned V_TOTAL_720P = V_ACT_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  // RGB565 field positions within a 16-bit pixel
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic miss;
  } stage1_t;

  // Expand by replicating the field MSBs into the new LSBs so full scale maps to 0xFF.
  function automatic rgb888_t rgb565_to_888(input logic [15:0] pix);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    rgb888_t    o;
    r   = pix[R_MSB:R_LSB];
    g   = pix[G_MSB:G_LSB];
    b   = pix[B_MSB:B_LSB];
    o.r = {r, r[4:2]};
    o.g = {g, g[5:4]};
    o.b = {b, b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/hdmi_data_out_if.sv
// Pixel FIFO pull interface plus video outputs toward the HDMI transmitter.
interface hdmi_data_out_if;
  logic        timing_en;
  logic        fifo_empty;
  logic [15:0] pix_data_in;
  logic        underflow_clr;
  logic        pix_req;
  logic        frame_start;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic [7:0]  red_out;
  logic [7:0]  green_out;
  logic [7:0]  blue_out;
  logic        underflow;

  modport master (
    output timing_en, fifo_empty, pix_data_in, underflow_clr,
    input  pix_req, frame_start, hs_out, vs_out, de_out,
    input  red_out, green_out, blue_out, underflow
  );

  modport slave (
    input  timing_en, fifo_empty, pix_data_in, underflow_clr,
    output pix_req, frame_start, hs_out, vs_out, de_out,
    output red_out, green_out, blue_out, underflow
  );
endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical counters with active, sync and frame-start decode.
module video_timing_gen #(
  parameter int unsigned H_ACT  = 1280,
  parameter int unsigned H_FP   = 110,
  parameter int unsigned H_SYNC = 40,
  parameter int unsigned H_BP   = 220,
  parameter int unsigned V_ACT  = 720,
  parameter int unsigned V_FP   = 5,
  parameter int unsigned V_SYNC = 5,
  parameter int unsigned V_BP   = 20
) (
  input  logic hdmi_pix_clk_in,
  input  logic rst,
  input  logic timing_en_i,
  output logic active_o,
  output logic hs_act_o,
  output logic vs_act_o,
  output logic frame_start_o
);

  localparam int unsigned HTotal = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast   = HW'(HTotal - 1);
  localparam logic [HW-1:0] HActEnd = HW'(H_ACT);
  localparam logic [HW-1:0] HsStart = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HsEnd   = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] VLast   = VW'(VTotal - 1);
  localparam logic [VW-1:0] VActEnd = VW'(V_ACT);
  localparam logic [VW-1:0] VsStart = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VsEnd   = VW'(V_ACT + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!timing_en_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge hdmi_pix_clk_in or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Gating with rst keeps the FIFO strobe quiet while reset is held with timing_en high.
  assign active_o      = rst && timing_en_i && (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
  assign hs_act_o      = timing_en_i && (h_cnt_q >= HsStart) && (h_cnt_q < HsEnd);
  assign vs_act_o      = timing_en_i && (v_cnt_q >= VsStart) && (v_cnt_q < VsEnd);
  assign frame_start_o = active_o && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/hdmi_data_out.sv
// HDMI transmit path: 720p timing, RGB565 FIFO pull, 2-stage output pipeline and underflow flag.
module hdmi_data_out
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACT  = H_ACT_720P,
  parameter int unsigned H_FP   = H_FP_720P,
  parameter int unsigned H_SYNC = H_SYNC_720P,
  parameter int unsigned H_BP   = H_BP_720P,
  parameter int unsigned V_ACT  = V_ACT_720P,
  parameter int unsigned V_FP   = V_FP_720P,
  parameter int unsigned V_SYNC = V_SYNC_720P,
  parameter int unsigned V_BP   = V_BP_720P,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input logic              hdmi_pix_clk_in,
  input logic              rst,
  hdmi_data_out_if.slave   hdmi
);

  localparam stage1_t S1Idle = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, miss: 1'b0};

  logic    req, hs_act, vs_act, frame_start;
  stage1_t s1_q, s1_d;
  logic    de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  rgb888_t rgb_q, rgb_d;
  logic    underflow_q, underflow_d;

  video_timing_gen #(
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .hdmi_pix_clk_in (hdmi_pix_clk_in),
    .rst             (rst),
    .timing_en_i     (hdmi.timing_en),
    .active_o        (req),
    .hs_act_o        (hs_act),
    .vs_act_o        (vs_act),
    .frame_start_o   (frame_start)
  );

  always_comb begin
    s1_d.de   = req;
    s1_d.hs   = hs_act ? HS_POL : ~HS_POL;
    s1_d.vs   = vs_act ? VS_POL : ~VS_POL;
    s1_d.miss = req && hdmi.fifo_empty;

    de_d  = s1_q.de;
    hs_d  = s1_q.hs;
    vs_d  = s1_q.vs;
    // Pixel data for the stage-1 request is presented now; a missed read is forced to black.
    rgb_d = (s1_q.de && !s1_q.miss) ? rgb565_to_888(hdmi.pix_data_in) : '0;

    // Set has priority over clear
    underflow_d = (req && hdmi.fifo_empty) || (underflow_q && !hdmi.underflow_clr);
  end

  always_ff @(posedge hdmi_pix_clk_in or negedge rst) begin
    if (!rst) begin
      s1_q        <= S1Idle;
      de_q        <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign hdmi.pix_req     = req;
  assign hdmi.frame_start = frame_start;
  assign hdmi.de_out      = de_q;
  assign hdmi.hs_out      = hs_q;
  assign hdmi.vs_out      = vs_q;
  assign hdmi.red_out     = rgb_q.r;
  assign hdmi.green_out   = rgb_q.g;
  assign hdmi.blue_out    = rgb_q.b;
  assign hdmi.underflow   = underflow_q;

endmodule

// File: tb/tb_hdmi_data_out.sv
// Randomized bench for hdmi_data_out on a shrunken raster, checked against a position-based model.
module tb_hdmi_data_out;

  localparam int HA = 16, HF = 3, HS = 2, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NF = HT * VT;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hdmi_data_out_if hdmi ();

  hdmi_data_out #(
    .H_ACT (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACT (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL (HSP), .VS_POL (VSP)
  ) dut (
    .hdmi_pix_clk_in (clk),
    .rst             (rst),
    .hdmi            (hdmi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: raster position since enable, plus what each of the two pipeline stages holds.
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        miss;
    logic [15:0] data;
  } stage_t;

  int     pos;
  stage_t s1, s2;
  bit     uf;

  logic        obs_req, obs_fs, obs_de, obs_hs, obs_vs, obs_uf;
  logic [23:0] obs_rgb;
  int cnt_req, cnt_fs, cnt_hs, cnt_vs, cnt_de, cnt_blank_rgb;
  int fs_cyc, de_cyc, cyc;

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r, g, b;
    r = (int'(p) >> 11) & 31;
    g = (int'(p) >> 5) & 63;
    b = int'(p) & 31;
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit en, input bit empty, input logic [15:0] data, input bit clr);
    int h, v;
    bit req, fs, hsa, vsa;
    logic [23:0] exp_rgb;
    hdmi.timing_en     = en;
    hdmi.fifo_empty    = empty;
    hdmi.pix_data_in   = data;
    hdmi.underflow_clr = clr;
    #1;
    h   = pos % HT;
    v   = pos / HT;
    req = en && h < HA && v < VA;
    fs  = req && pos == 0;
    hsa = en && h >= HA + HF && h < HA + HF + HS;
    vsa = en && v >= VA + VF && v < VA + VF + VS;
    exp_rgb = (s2.de && !s2.miss) ? expand(s2.data) : 24'h0;

    obs_req = hdmi.pix_req;
    obs_fs  = hdmi.frame_start;
    obs_de  = hdmi.de_out;
    obs_hs  = hdmi.hs_out;
    obs_vs  = hdmi.vs_out;
    obs_rgb = {hdmi.red_out, hdmi.green_out, hdmi.blue_out};
    obs_uf  = hdmi.underflow;

    check_eq("pix_req", obs_req, req);
    check_eq("frame_start", obs_fs, fs);
    check_eq("de_out", obs_de, s2.de);
    check_eq("hs_out", obs_hs, s2.hs ? HSP : !HSP);
    check_eq("vs_out", obs_vs, s2.vs ? VSP : !VSP);
    check_eq("rgb", obs_rgb, exp_rgb);
    check_eq("underflow", obs_uf, uf);

    cnt_req += int'(obs_req);
    cnt_fs  += int'(obs_fs);
    cnt_de  += int'(obs_de);
    cnt_hs  += int'(obs_hs == HSP);
    cnt_vs  += int'(obs_vs == VSP);
    if (!obs_de && obs_rgb != 24'h0) cnt_blank_rgb++;
    if (obs_fs && fs_cyc < 0) fs_cyc = cyc;
    if (obs_de && de_cyc < 0) de_cyc = cyc;
    cyc++;

    @(posedge clk);
    s2      = s1;
    s2.data = data;
    s1      = '{de: req, hs: hsa, vs: vsa, miss: req && empty, data: 16'h0};
    uf      = (req && empty) || (uf && !clr);
    pos     = en ? (pos + 1) % NF : 0;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    cnt_req = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_blank_rgb = 0;
    fs_cyc = -1; de_cyc = -1; cyc = 0;
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it on a later falling edge.
  task automatic apply_reset(input int hold);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_pix_req", hdmi.pix_req, 1'b0);
    check_eq("rst_frame_start", hdmi.frame_start, 1'b0);
    check_eq("rst_de", hdmi.de_out, 1'b0);
    check_eq("rst_hs", hdmi.hs_out, !HSP);
    check_eq("rst_vs", hdmi.vs_out, !VSP);
    check_eq("rst_rgb", {hdmi.red_out, hdmi.green_out, hdmi.blue_out}, 24'h0);
    check_eq("rst_underflow", hdmi.underflow, 1'b0);
    pos = 0;
    s1  = '0;
    s2  = '0;
    uf  = 1'b0;
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    hdmi.timing_en     = 1'b1;
    hdmi.fifo_empty    = 1'b0;
    hdmi.pix_data_in   = 16'h0;
    hdmi.underflow_clr = 1'b0;
    clear_stats();
    @(negedge clk);
    apply_reset(3);

    // Frame 1: directed colours on line 1, frame_start-to-de alignment, blanking stays black
    clear_stats();
    for (int i = 0; i < NF; i++) begin
      d = 16'($urandom);
      if (i == HT + 1) d = 16'hF800;
      if (i == HT + 2) d = 16'h07E0;
      if (i == HT + 3) d = 16'h001F;
      if (i == HT + 4) d = 16'h8410;
      cycle(1'b1, 1'b0, d, 1'($urandom_range(0, 1)));
      if (i == HT + 2) check_eq("rgb_red", obs_rgb, 24'hFF0000);
      if (i == HT + 3) check_eq("rgb_green", obs_rgb, 24'h00FF00);
      if (i == HT + 4) check_eq("rgb_blue", obs_rgb, 24'h0000FF);
      // 6-bit green field of 0x8410 is 100000b, which replicates to 0x82
      if (i == HT + 5) check_eq("rgb_8410", obs_rgb, 24'h848284);
    end
    check_eq("fs_to_de_latency", 32'(de_cyc - fs_cyc), 32'd2);
    check_eq("blank_rgb_nonzero", 32'(cnt_blank_rgb), 32'd0);

    // Frame 2: per-frame totals
    clear_stats();
    for (int i = 0; i < NF; i++) cycle(1'b1, 1'b0, 16'($urandom), 1'b0);
    check_eq("frame_req_count", 32'(cnt_req), 32'(HA * VA));
    check_eq("frame_fs_count", 32'(cnt_fs), 32'd1);
    check_eq("frame_hs_count", 32'(cnt_hs), 32'(HS * VT));
    check_eq("frame_vs_count", 32'(cnt_vs), 32'(VS * HT));
    check_eq("frame_de_count", 32'(cnt_de), 32'(HA * VA));

    // Frame 3: underflow on pixel 10 of line 3, clear, then set racing clear
    for (int i = 0; i < NF; i++) begin
      cycle(1'b1, (i == 3 * HT + 9) || (i == 6 * HT + 2), 16'($urandom),
            (i == 5 * HT) || (i == 6 * HT + 2));
      if (i == 3 * HT + 11) check_eq("uf_pixel_black", obs_rgb, 24'h0);
      if (i == 3 * HT + 11) check_eq("uf_set", obs_uf, 1'b1);
      if (i == 5 * HT - 1)  check_eq("uf_sticky", obs_uf, 1'b1);
      if (i == 5 * HT + 1)  check_eq("uf_cleared", obs_uf, 1'b0);
      if (i == 6 * HT + 3)  check_eq("uf_set_wins", obs_uf, 1'b1);
    end

    // Two frames of random empties, clears and data
    for (int i = 0; i < 2 * NF; i++)
      cycle(1'b1, $urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 31) == 0);

    // Drop timing_en at h=10, v=5, then re-enable
    while (pos != 5 * HT + 10) cycle(1'b1, 1'b0, 16'($urandom), 1'b0);
    cycle(1'b0, 1'b0, 16'($urandom), 1'b0);
    check_eq("drop_req_same_cycle", obs_req, 1'b0);
    cycle(1'b0, 1'b0, 16'($urandom), 1'b0);
    check_eq("drop_de_still_flushing", obs_de, 1'b1);
    cycle(1'b0, 1'b0, 16'($urandom), 1'b0);
    check_eq("drop_de_idle", obs_de, 1'b0);
    check_eq("drop_rgb_idle", obs_rgb, 24'h0);
    repeat (5) cycle(1'b0, 1'b0, 16'($urandom), 1'b0);
    cycle(1'b1, 1'b0, 16'($urandom), 1'b0);
    check_eq("reenable_frame_start", obs_fs, 1'b1);

    // Reset at h=8, v=2, then a clean frame from the origin
    while (pos != 2 * HT + 8) cycle(1'b1, 1'b0, 16'($urandom), 1'b0);
    apply_reset(2);
    cycle(1'b1, 1'b0, 16'($urandom), 1'b0);
    check_eq("post_reset_frame_start", obs_fs, 1'b1);
    for (int i = 1; i < NF; i++)
      cycle(1'b1, $urandom_range(0, 31) == 0, 16'($urandom), $urandom_range(0, 15) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
